// File: rtl/game_controller.sv
// game_controller
//   Input conditioning and game sequencing for the runner game. Debounces the
//   jump button, registers the speed/difficulty switch encodings, runs the
//   IDLE/RUN/DEAD state machine and produces the game_tick enable that paces
//   the physics, map, score, audio and display engines. Everything runs in
//   the CLK100MHZ domain.
//
// Ports
//   CLK100MHZ      in   system clock
//   reset_btn      in   synchronous active-high reset
//   jump_btn       in   raw asynchronous jump/start button
//   speed_in[3:0]  in   speed switches, highest set bit wins
//   difficulty_in  in   difficulty switches, highest set bit wins
//   isdead         in   collision flag from the physics engine
//   jump           out  one-cycle pulse on a debounced press, gated by state
//   jump_level     out  debounced button level
//   start          out  high while the game is running
//   game_tick      out  one-cycle engine enable (RUN and DEAD only)
//   speed[2:0]     out  registered speed code, 2..6
//   difficulty     out  registered difficulty code, 0..3
//   state[1:0]     out  00 IDLE, 01 RUN, 10 DEAD
module game_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ACC_W           = 27,
    parameter int unsigned DEAD_HOLD_TICKS = 8
) (
    input  logic       CLK100MHZ,
    input  logic       reset_btn,
    input  logic       jump_btn,
    input  logic [3:0] speed_in,
    input  logic [3:0] difficulty_in,
    input  logic       isdead,
    output logic       jump,
    output logic       jump_level,
    output logic       start,
    output logic       game_tick,
    output logic [2:0] speed,
    output logic [1:0] difficulty,
    output logic [1:0] state
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (DEAD_HOLD_TICKS > 0) ? $clog2(DEAD_HOLD_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEAD_HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    // Button conditioning
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             w_rise;

    // Switch encodings
    logic [2:0] r_speed;
    logic [1:0] r_diff;
    logic [2:0] w_speed_enc;
    logic [1:0] w_diff_enc;

    // Sequencing
    logic [1:0]        r_state;
    state_t            w_state;
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W:0]    w_sum;
    logic              r_tick;
    logic [HOLD_W-1:0] r_hold;
    logic              w_hold_full;
    logic              w_jump;
    logic              w_start;
    logic              w_acc_clr;
    logic              w_acc_run;
    logic              w_hold_clr;

    // ------------------------------------------------------------------
    // Two-flop synchronizer and debounce. The level only follows the
    // synchronized button after it has disagreed for DEBOUNCE_CYCLES
    // consecutive edges; any agreement restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ) begin
        if (reset_btn) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync1   <= jump_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_level  <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_rise = r_level & ~r_level_d;

    // ------------------------------------------------------------------
    // Priority encoders
    // ------------------------------------------------------------------
    always_comb begin
        w_speed_enc = 3'd2;
        if (speed_in[3])      w_speed_enc = 3'd6;
        else if (speed_in[2]) w_speed_enc = 3'd5;
        else if (speed_in[1]) w_speed_enc = 3'd4;
        else if (speed_in[0]) w_speed_enc = 3'd3;
    end

    always_comb begin
        w_diff_enc = 2'd0;
        if (difficulty_in[3])      w_diff_enc = 2'd3;
        else if (difficulty_in[2]) w_diff_enc = 2'd2;
        else if (difficulty_in[1]) w_diff_enc = 2'd1;
    end

    // ------------------------------------------------------------------
    // State machine: next state and control decode
    // ------------------------------------------------------------------
    assign w_state     = state_t'(r_state);
    assign w_hold_full = (r_hold == HOLD_MAX);

    always_comb begin
        w_state_nxt = w_state;
        w_jump      = 1'b0;
        w_start     = 1'b0;
        w_acc_clr   = 1'b0;
        w_acc_run   = 1'b0;
        w_hold_clr  = 1'b0;
        case (w_state)
            ST_IDLE: begin
                w_jump     = w_rise;
                w_acc_clr  = 1'b1;
                w_hold_clr = 1'b1;
                if (w_rise) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_start    = 1'b1;
                w_acc_run  = 1'b1;
                w_hold_clr = 1'b1;
                // A collision in the same cycle as a press takes priority
                // and swallows the press.
                if (isdead) w_state_nxt = ST_DEAD;
                else        w_jump      = w_rise;
            end
            ST_DEAD: begin
                w_acc_run = 1'b1;
                if (w_rise && w_hold_full) begin
                    w_state_nxt = ST_RUN;
                    w_acc_clr   = 1'b1;
                    w_hold_clr  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_clr   = 1'b1;
                w_hold_clr  = 1'b1;
            end
        endcase
    end

    // Speed is zero-extended; the extra top bit of the sum is the carry.
    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(r_speed);

    // ------------------------------------------------------------------
    // State register and sequencing datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ) begin
        if (reset_btn) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_tick  <= 1'b0;
            r_hold  <= '0;
            r_speed <= 3'd2;
            r_diff  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_acc_clr) begin
                r_acc  <= '0;
                r_tick <= 1'b0;
            end else if (w_acc_run) begin
                r_acc  <= w_sum[ACC_W-1:0];
                r_tick <= w_sum[ACC_W];
            end else begin
                r_tick <= 1'b0;
            end

            // Counts ticks seen while dead; saturates so a long wait still
            // allows a restart.
            if (w_hold_clr) begin
                r_hold <= '0;
            end else if (r_tick && !w_hold_full) begin
                r_hold <= r_hold + 1'b1;
            end

            // Frozen during play; the entry edge itself still captures.
            if (w_state != ST_RUN) begin
                r_speed <= w_speed_enc;
                r_diff  <= w_diff_enc;
            end
        end
    end

    assign jump       = w_jump;
    assign jump_level = r_level;
    assign start      = w_start;
    assign game_tick  = r_tick;
    assign speed      = r_speed;
    assign difficulty = r_diff;
    assign state      = r_state;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

    logic       clk = 1'b0;
    logic       reset_btn;
    logic       jump_btn;
    logic [3:0] speed_in;
    logic [3:0] difficulty_in;
    logic       isdead;
    logic       jump;
    logic       jump_level;
    logic       start;
    logic       game_tick;
    logic [2:0] speed;
    logic [1:0] difficulty;
    logic [1:0] state;

    game_controller #(
        .DEBOUNCE_CYCLES (4),
        .ACC_W           (4),
        .DEAD_HOLD_TICKS (2)
    ) dut (
        .CLK100MHZ     (clk),
        .reset_btn     (reset_btn),
        .jump_btn      (jump_btn),
        .speed_in      (speed_in),
        .difficulty_in (difficulty_in),
        .isdead        (isdead),
        .jump          (jump),
        .jump_level    (jump_level),
        .start         (start),
        .game_tick     (game_tick),
        .speed         (speed),
        .difficulty    (difficulty),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Count of rising edges so far; stable between edges.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {F_JUMP, F_LEVEL, F_START, F_TICK, F_SPEED, F_DIFF, F_STATE} field_t;

    typedef struct {
        string       name;
        int unsigned at;
        field_t      f;
        int unsigned val;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input int unsigned at, input field_t f, input int unsigned val);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.f    = f;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic int unsigned field_val(input field_t f);
        case (f)
            F_JUMP:  return int'(jump);
            F_LEVEL: return int'(jump_level);
            F_START: return int'(start);
            F_TICK:  return int'(game_tick);
            F_SPEED: return int'(speed);
            F_DIFF:  return int'(difficulty);
            default: return int'(state);
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle, mid-way through the
    // low clock phase.
    always @(negedge clk) begin
        #2;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                int unsigned act;
                act = field_val(sb[i].f);
                n_checks++;
                if (act != sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %0d, expected %0d",
                             sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s (cycle %0d): check missed, expected %0d",
                         sb[i].name, sb[i].at, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag, input int unsigned at);
        chk({tag, "_state"}, at, F_STATE, 0);
        chk({tag, "_start"}, at, F_START, 0);
        chk({tag, "_jump"},  at, F_JUMP,  0);
        chk({tag, "_tick"},  at, F_TICK,  0);
        chk({tag, "_level"}, at, F_LEVEL, 0);
        chk({tag, "_speed"}, at, F_SPEED, 2);
        chk({tag, "_diff"},  at, F_DIFF,  0);
    endtask

    initial begin
        reset_btn     = 1'b1;
        jump_btn      = 1'b0;
        speed_in      = 4'b0000;
        difficulty_in = 4'b0000;
        isdead        = 1'b0;

        // Reset for edges 1 and 2
        wait_until(2);
        reset_btn = 1'b0;
        chk_reset("rst0", 2);

        // Switches captured in IDLE, then bouncing button
        speed_in      = 4'b0100;
        difficulty_in = 4'b1000;
        chk("idle_speed", 3, F_SPEED, 5);
        chk("idle_diff",  3, F_DIFF,  3);
        for (int t = 2; t <= 27; t++) begin
            chk("bounce_jump",  t, F_JUMP,  0);
            chk("bounce_level", t, F_LEVEL, 0);
        end
        for (int i = 0; i < 10; i++) begin
            jump_btn = (i % 2 == 0);
            wait_until(2 + 2 * (i + 1));
        end
        // Final steady press at cycle 22
        jump_btn = 1'b1;
        chk("press_level",     28, F_LEVEL, 1);
        chk("press_jump",      28, F_JUMP,  1);
        chk("press_state_idle",28, F_STATE, 0);
        chk("jump_one_cycle",  29, F_JUMP,  0);
        chk("run_state",       29, F_STATE, 1);
        chk("run_start",       29, F_START, 1);
        chk("run_speed",       29, F_SPEED, 5);
        chk("run_diff",        29, F_DIFF,  3);
        chk("run5_tick_pre",   32, F_TICK,  0);
        chk("run5_tick",       33, F_TICK,  1);
        chk("run5_tick_post",  34, F_TICK,  0);

        wait_until(29);
        speed_in      = 4'b0000;
        difficulty_in = 4'b0000;
        chk("frozen_speed", 31, F_SPEED, 5);
        chk("frozen_diff",  31, F_DIFF,  3);

        wait_until(34);
        jump_btn = 1'b0;
        chk("release_level_hi", 39, F_LEVEL, 1);
        chk("release_level_lo", 40, F_LEVEL, 0);

        // Press whose rise coincides with a collision
        wait_until(40);
        jump_btn = 1'b1;
        chk("die_level",      46, F_LEVEL, 1);
        chk("die_jump_kill",  46, F_JUMP,  0);
        chk("die_state_run",  46, F_STATE, 1);
        chk("dead_state",     47, F_STATE, 2);
        chk("dead_start",     47, F_START, 0);
        wait_until(44);
        jump_btn = 1'b0;
        wait_until(46);
        isdead = 1'b1;
        wait_until(47);
        isdead = 1'b0;

        wait_until(48);
        difficulty_in = 4'b0010;
        chk("dead_speed_upd", 48, F_SPEED, 2);
        chk("dead_diff_upd0", 48, F_DIFF,  0);
        chk("dead_diff_upd1", 49, F_DIFF,  1);
        chk("dead_tick1",     49, F_TICK,  1);
        chk("dead_tick1_post",50, F_TICK,  0);
        chk("early_level",    56, F_LEVEL, 1);
        chk("early_jump",     56, F_JUMP,  0);
        chk("dead_tick2_pre", 56, F_TICK,  0);
        chk("dead_tick2",     57, F_TICK,  1);
        chk("early_ignored",  57, F_STATE, 2);

        // Early press: rise at 56, before the second dead tick
        wait_until(50);
        jump_btn = 1'b1;
        wait_until(54);
        jump_btn = 1'b0;

        // Late press: rise at 66, hold already full
        wait_until(60);
        jump_btn = 1'b1;
        chk("dead_tick3",     65, F_TICK,  1);
        chk("late_jump",      66, F_JUMP,  0);
        chk("late_state",     66, F_STATE, 2);
        chk("restart_state",  67, F_STATE, 1);
        chk("restart_start",  67, F_START, 1);
        chk("restart_tick",   67, F_TICK,  0);
        chk("run2_tick_pre",  74, F_TICK,  0);
        chk("run2_tick_a",    75, F_TICK,  1);
        chk("run2_tick_post", 76, F_TICK,  0);
        chk("run2_tick_pre2", 82, F_TICK,  0);
        chk("run2_tick_b",    83, F_TICK,  1);

        // Second death, switch to speed 6 while dead
        wait_until(84);
        isdead = 1'b1;
        chk("dead2_state", 85, F_STATE, 2);
        chk("dead2_tick0", 85, F_TICK,  0);
        wait_until(85);
        isdead   = 1'b0;
        speed_in = 4'b1000;
        jump_btn = 1'b0;
        chk("dead2_speed",  86, F_SPEED, 6);
        chk("dead2_tick_a", 88, F_TICK,  1);
        chk("dead2_tick_b", 91, F_TICK,  1);
        chk("dead2_lvl_lo", 91, F_LEVEL, 0);

        wait_until(91);
        jump_btn = 1'b1;
        chk("restart2_state", 98, F_STATE, 1);
        begin
            int unsigned pat [8];
            pat = '{0, 0, 1, 0, 0, 1, 0, 1};
            for (int k = 0; k < 8; k++) chk("run6_tick", 99 + k, F_TICK, pat[k]);
        end
        wait_until(99);
        speed_in = 4'b0001;
        chk("run6_frozen", 101, F_SPEED, 6);

        // Reset mid-RUN with the button held
        wait_until(108);
        reset_btn = 1'b1;
        wait_until(109);
        reset_btn = 1'b0;
        chk_reset("rst1", 109);
        chk("post_rst_speed", 110, F_SPEED, 3);
        chk("post_rst_diff",  110, F_DIFF,  1);
        chk("held_jump_pre",  114, F_JUMP,  0);
        chk("held_jump",      115, F_JUMP,  1);
        chk("held_level",     115, F_LEVEL, 1);
        chk("held_run",       116, F_STATE, 1);

        // Reset into IDLE, then an illegal state encoding
        wait_until(118);
        reset_btn = 1'b1;
        jump_btn  = 1'b0;
        wait_until(119);
        reset_btn     = 1'b0;
        speed_in      = 4'b0010;
        difficulty_in = 4'b0101;
        chk("rst2_state", 119, F_STATE, 0);
        chk("enc_speed4", 120, F_SPEED, 4);
        chk("enc_diff2",  120, F_DIFF,  2);
        chk("bad_state",  121, F_STATE, 3);
        chk("bad_start",  121, F_START, 0);
        chk("bad_tick",   121, F_TICK,  0);
        chk("bad_jump",   121, F_JUMP,  0);
        chk("bad_recover",122, F_STATE, 0);
        chk("bad_start2", 122, F_START, 0);
        chk("bad_tick2",  122, F_TICK,  0);
        chk("idle_state", 123, F_STATE, 0);
        chk("idle_tick",  123, F_TICK,  0);
        chk("enc_diff0",  123, F_DIFF,  0);
        chk("enc_speed2", 123, F_SPEED, 2);
        wait_until(121);
        force dut.r_state = 2'b11;
        #4;
        release dut.r_state;
        wait_until(122);
        difficulty_in = 4'b0001;
        speed_in      = 4'b0000;

        wait_until(126);
        #3;
        while (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s (cycle %0d): check never evaluated, expected %0d",
                     sb[0].name, sb[0].at, sb[0].val);
            sb.delete(0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
